gm_bus_arb: RTL and testbench

- Two-master, one-slave Wishbone arbiter for the framebuffer memory port.
- Shares the memory between the video line fetcher (master 0, priority) and the CPU (master 1).
- Keeps the grant on the fetcher across the short gaps between its per-word cycles, so a 20-word line fetch is not interleaved with CPU traffic.
- Guarantees the CPU bounded access latency through a starvation counter.

---
 rtl/gm_bus_arb_if.sv | 27 ++
 rtl/gm_bus_arb.sv | 146 ++++++++++++++
 tb/tb_gm_bus_arb.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gm_bus_arb_if.sv
// Wishbone link between one master and one slave.
// Ports (modports):
//   master - drives cyc/stb/we/adr/sel/dat_m, receives dat_s/ack
//   slave  - receives cyc/stb/we/adr/sel/dat_m, drives dat_s/ack
interface gm_bus_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_m;
    logic [DW-1:0]   dat_s;
    logic            ack;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack
    );
endinterface

// File: rtl/gm_bus_arb.sv
// Two-master, one-slave Wishbone arbiter for the framebuffer memory port.
// Video fetcher (v_bus) has priority and keeps its grant for HOLD_CYCLES
// across gaps between per-word cycles; the CPU (c_bus) is guaranteed access
// once it has waited CPU_MAX_WAIT cycles.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-low reset
//   v_bus  - video master link (arbiter is its slave)
//   c_bus  - CPU master link (arbiter is its slave)
//   s_bus  - memory slave link (arbiter is its master)
//   grant  - one-hot grant, bit0 video, bit1 CPU, 00 when idle
module gm_bus_arb #(
    parameter int          AW           = 32,
    parameter int          DW           = 32,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned CPU_MAX_WAIT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    gm_bus_arb_if.slave     v_bus,
    gm_bus_arb_if.slave     c_bus,
    gm_bus_arb_if.master    s_bus,
    output logic [1:0]      grant
);
    // A zero-width hold counter is illegal, so HOLD_CYCLES == 0 keeps one bit.
    localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned WW = $clog2(CPU_MAX_WAIT + 1);

    localparam logic [HW-1:0] HoldInit = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;
    localparam logic [WW-1:0] WaitMax  = WW'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VID,
        S_VID_HOLD,
        S_CPU
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          starved;

    assign starved = (wait_cnt_q == WaitMax);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (v_bus.cyc && !starved) begin
                    state_d = S_VID;
                end else if (c_bus.cyc) begin
                    state_d = S_CPU;
                end
            end
            S_VID: begin
                if (!v_bus.cyc) begin
                    if (HOLD_CYCLES > 0) begin
                        state_d    = S_VID_HOLD;
                        hold_cnt_d = HoldInit;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_VID_HOLD: begin
                // A returning video request beats both hold expiry and starvation.
                if (v_bus.cyc) begin
                    state_d = S_VID;
                end else if (hold_cnt_q == '0 || starved) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            S_CPU: begin
                if (!c_bus.cyc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counts CPU waiting cycles outside its own grant, saturating at the limit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_CPU || !c_bus.cyc) begin
            wait_cnt_d = '0;
        end else if (!starved) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    always_comb begin
        s_bus.cyc   = 1'b0;
        s_bus.stb   = 1'b0;
        s_bus.we    = 1'b0;
        s_bus.adr   = '0;
        s_bus.sel   = '0;
        s_bus.dat_m = '0;
        v_bus.ack   = 1'b0;
        c_bus.ack   = 1'b0;
        grant       = 2'b00;
        unique case (state_q)
            S_VID: begin
                s_bus.cyc   = v_bus.cyc;
                s_bus.stb   = v_bus.stb;
                s_bus.we    = v_bus.we;
                s_bus.adr   = v_bus.adr;
                s_bus.sel   = v_bus.sel;
                s_bus.dat_m = v_bus.dat_m;
                v_bus.ack   = s_bus.ack;
                grant       = 2'b01;
            end
            S_CPU: begin
                s_bus.cyc   = c_bus.cyc;
                s_bus.stb   = c_bus.stb;
                s_bus.we    = c_bus.we;
                s_bus.adr   = c_bus.adr;
                s_bus.sel   = c_bus.sel;
                s_bus.dat_m = c_bus.dat_m;
                c_bus.ack   = s_bus.ack;
                grant       = 2'b10;
            end
            default: begin
            end
        endcase
    end

    assign v_bus.dat_s = s_bus.dat_s;
    assign c_bus.dat_s = s_bus.dat_s;
endmodule

// File: tb/tb_gm_bus_arb.sv
module tb_gm_bus_arb;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int HOLD = 2;
    localparam int MAXW = 8;

    // Reference model ownership: who holds the memory right now.
    localparam int NONE = 0;
    localparam int VID  = 1;
    localparam int CPU  = 2;
    localparam int RES  = 3;  // bus idle but reserved for the video fetcher

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] grant;

    int checks;
    int errors;
    int own;
    int hold_left;
    int waited;
    bit saw_cpu;

    always #5 clk_i = ~clk_i;

    gm_bus_arb_if #(.AW(AW), .DW(DW)) v_bus ();
    gm_bus_arb_if #(.AW(AW), .DW(DW)) c_bus ();
    gm_bus_arb_if #(.AW(AW), .DW(DW)) s_bus ();

    gm_bus_arb #(
        .AW          (AW),
        .DW          (DW),
        .HOLD_CYCLES (HOLD),
        .CPU_MAX_WAIT(MAXW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .v_bus(v_bus),
        .c_bus(c_bus),
        .s_bus(s_bus),
        .grant(grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        v_bus.cyc = 0; v_bus.stb = 0; v_bus.we = 0; v_bus.adr = '0; v_bus.sel = '0;
        v_bus.dat_m = '0;
        c_bus.cyc = 0; c_bus.stb = 0; c_bus.we = 0; c_bus.adr = '0; c_bus.sel = '0;
        c_bus.dat_m = '0;
        s_bus.ack = 0; s_bus.dat_s = '0;
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        eg = (own == VID) ? 2'b01 : (own == CPU) ? 2'b10 : 2'b00;
        check("grant", grant, eg);
        if (own == VID) begin
            check("s_cyc", s_bus.cyc, v_bus.cyc);
            check("s_stb", s_bus.stb, v_bus.stb);
            check("s_we", s_bus.we, v_bus.we);
            check("s_adr", s_bus.adr, v_bus.adr);
            check("s_sel", s_bus.sel, v_bus.sel);
            check("s_dat_m", s_bus.dat_m, v_bus.dat_m);
        end else if (own == CPU) begin
            check("s_cyc", s_bus.cyc, c_bus.cyc);
            check("s_stb", s_bus.stb, c_bus.stb);
            check("s_we", s_bus.we, c_bus.we);
            check("s_adr", s_bus.adr, c_bus.adr);
            check("s_sel", s_bus.sel, c_bus.sel);
            check("s_dat_m", s_bus.dat_m, c_bus.dat_m);
        end else begin
            check("s_cyc", s_bus.cyc, 0);
            check("s_stb", s_bus.stb, 0);
            check("s_we", s_bus.we, 0);
            check("s_adr", s_bus.adr, 0);
            check("s_sel", s_bus.sel, 0);
            check("s_dat_m", s_bus.dat_m, 0);
        end
        check("v_ack", v_bus.ack, (own == VID) ? s_bus.ack : 1'b0);
        check("c_ack", c_bus.ack, (own == CPU) ? s_bus.ack : 1'b0);
        check("v_dat_s", v_bus.dat_s, s_bus.dat_s);
        check("c_dat_s", c_bus.dat_s, s_bus.dat_s);
    endtask

    // Applies the arbitration rules to the inputs present at a rising edge.
    task automatic model_clock();
        bit starved;
        int nxt_wait;
        starved = (waited == MAXW);
        if (own == CPU || !c_bus.cyc) nxt_wait = 0;
        else nxt_wait = (waited < MAXW) ? waited + 1 : MAXW;
        case (own)
            NONE: begin
                if (v_bus.cyc && !starved) own = VID;
                else if (c_bus.cyc) own = CPU;
            end
            VID: begin
                if (!v_bus.cyc) begin
                    if (HOLD > 0) begin
                        own = RES;
                        hold_left = HOLD;
                    end else begin
                        own = NONE;
                    end
                end
            end
            RES: begin
                if (v_bus.cyc) begin
                    own = VID;
                end else begin
                    hold_left--;
                    if (hold_left == 0 || starved) own = NONE;
                end
            end
            CPU: if (!c_bus.cyc) own = NONE;
            default: own = NONE;
        endcase
        waited = nxt_wait;
    endtask

    // Called just after inputs are driven following a falling edge.
    task automatic run_cycle();
        #1;
        check_outputs();
        @(posedge clk_i);
        model_clock();
        @(negedge clk_i);
    endtask

    task automatic drive_rand();
        if ($urandom_range(5) == 0) v_bus.cyc = ~v_bus.cyc;
        if ($urandom_range(7) == 0) c_bus.cyc = ~c_bus.cyc;
        v_bus.stb   = v_bus.cyc & 1'($urandom_range(1));
        c_bus.stb   = c_bus.cyc & 1'($urandom_range(1));
        v_bus.we    = 1'($urandom_range(1));
        c_bus.we    = 1'($urandom_range(1));
        v_bus.adr   = $urandom;
        c_bus.adr   = $urandom;
        v_bus.sel   = 4'($urandom);
        c_bus.sel   = 4'($urandom);
        v_bus.dat_m = $urandom;
        c_bus.dat_m = $urandom;
        s_bus.ack   = 1'($urandom_range(1));
        s_bus.dat_s = $urandom;
    endtask

    initial begin
        checks = 0; errors = 0;
        own = NONE; hold_left = 0; waited = 0; saw_cpu = 0;
        idle_inputs();
        rst_i = 0;
        #1;
        check_outputs();
        repeat (2) @(negedge clk_i);
        rst_i = 1;

        // Video alone: granted one cycle after the request, ack routed to video.
        v_bus.cyc = 1; v_bus.stb = 1; v_bus.adr = 32'h1000;
        run_cycle();
        s_bus.ack = 1;
        run_cycle();
        check("vid_alone_grant", grant, 2'b01);
        idle_inputs();
        repeat (4) run_cycle();

        for (int i = 0; i < 1500; i++) begin
            drive_rand();
            run_cycle();
        end

        // Starvation: video keeps re-requesting inside the hold window.
        idle_inputs();
        repeat (4) run_cycle();
        c_bus.cyc = 1; c_bus.stb = 1; c_bus.adr = 32'h2000;
        for (int i = 0; i < 80; i++) begin
            v_bus.cyc = ((i % 5) < 3);
            v_bus.stb = v_bus.cyc;
            s_bus.ack = 1'($urandom_range(1));
            run_cycle();
            if (grant == 2'b10) saw_cpu = 1;
        end
        check("starve_cpu_grant", saw_cpu, 1);
        idle_inputs();
        repeat (4) run_cycle();

        // Asynchronous reset in the middle of a video transfer.
        v_bus.cyc = 1; v_bus.stb = 1; v_bus.adr = 32'h3000;
        repeat (3) run_cycle();
        s_bus.ack = 1;
        #2;
        rst_i = 0;
        #1;
        own = NONE; hold_left = 0; waited = 0;
        check("arst_grant", grant, 2'b00);
        check("arst_s_cyc", s_bus.cyc, 0);
        check("arst_v_ack", v_bus.ack, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_i = 1;
        run_cycle();
        run_cycle();
        check("post_rst_grant", grant, 2'b01);

        for (int i = 0; i < 600; i++) begin
            drive_rand();
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
